// File: rtl/up_bus_arbiter_if.sv
// up_* register-access bundle: write and read request/ack channels.
// N lanes share one rdata bus; master drives requests, slave drives acks.
interface up_bus_arbiter_if #(
    parameter int N          = 2,
    parameter int ADDR_WIDTH = 14
);
    logic [N-1:0]            wreq;
    logic [N*ADDR_WIDTH-1:0] waddr;
    logic [N*32-1:0]         wdata;
    logic [N-1:0]            wack;
    logic [N-1:0]            rreq;
    logic [N*ADDR_WIDTH-1:0] raddr;
    logic [31:0]             rdata;
    logic [N-1:0]            rack;

    modport master (
        output wreq, waddr, wdata, rreq, raddr,
        input  wack, rdata, rack
    );

    modport slave (
        input  wreq, waddr, wdata, rreq, raddr,
        output wack, rdata, rack
    );
endinterface

// File: rtl/up_bus_arbiter.sv
// Round-robin arbiter sharing one up_* register port among NUM_REQ requesters.
// Ports: up_clk/up_rstn; s = requester side (slave modport, NUM_REQ lanes);
// m = downstream port (master modport, 1 lane); busy, grant_id, timeout status.
module up_bus_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          ADDR_WIDTH     = 14,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADDEAD,
    localparam int         IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   up_clk,
    input  logic                   up_rstn,
    up_bus_arbiter_if.slave        s,
    up_bus_arbiter_if.master       m,
    output logic                   busy,
    output logic [IW-1:0]          grant_id,
    output logic                   timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t                state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         id;
    logic                  is_wr;
    logic [CW-1:0]         cnt;

    logic [NUM_REQ-1:0]    cand;
    logic                  found;
    logic [IW-1:0]         win;
    int                    idx;
    logic                  win_wr;
    logic [ADDR_WIDTH-1:0] win_waddr;
    logic [31:0]           win_wdata;
    logic [ADDR_WIDTH-1:0] win_raddr;
    logic [NUM_REQ-1:0]    onehot;
    logic [IW-1:0]         ptr_nxt;
    logic                  ack_in;

    assign cand = s.wreq | s.rreq;

    // Scan from the highest offset down so the last hit is the
    // first candidate at or after the pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (cand[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        win_wr    = 1'b0;
        win_waddr = '0;
        win_wdata = '0;
        win_raddr = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (IW'(j) == win) begin
                win_wr    = s.wreq[j];
                win_waddr = s.waddr[j*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = s.wdata[j*32 +: 32];
                win_raddr = s.raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign onehot  = NUM_REQ'(1) << id;
    assign ptr_nxt = (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    // Only the ack matching the latched type counts.
    assign ack_in  = is_wr ? m.wack : m.rack;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state    <= IDLE;
            ptr      <= '0;
            id       <= '0;
            is_wr    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            timeout  <= 1'b0;
            m.wreq   <= 1'b0;
            m.rreq   <= 1'b0;
            m.waddr  <= '0;
            m.wdata  <= '0;
            m.raddr  <= '0;
            s.wack   <= '0;
            s.rack   <= '0;
            s.rdata  <= '0;
        end else begin
            m.wreq  <= 1'b0;
            m.rreq  <= 1'b0;
            s.wack  <= '0;
            s.rack  <= '0;
            s.rdata <= '0;
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        id       <= win;
                        grant_id <= win;
                        is_wr    <= win_wr;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                        if (win_wr) begin
                            m.wreq  <= 1'b1;
                            m.waddr <= win_waddr;
                            m.wdata <= win_wdata;
                        end else begin
                            m.rreq  <= 1'b1;
                            m.raddr <= win_raddr;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (ack_in) begin
                        state <= ACK;
                        if (is_wr) begin
                            s.wack <= onehot;
                        end else begin
                            s.rack  <= onehot;
                            s.rdata <= m.rdata;
                        end
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= ACK;
                        timeout <= 1'b1;
                        if (is_wr) begin
                            s.wack <= onehot;
                        end else begin
                            s.rack  <= onehot;
                            s.rdata <= TIMEOUT_RDATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    ptr   <= ptr_nxt;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Testbench for up_bus_arbiter: directed requester/slave scenarios
// checked against a transaction-timeline model every cycle.
module tb_up_bus_arbiter;

    localparam int          N    = 2;
    localparam int          AW   = 14;
    localparam int          TO   = 64;
    localparam logic [31:0] DEAD = 32'hDEADDEAD;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       busy;
    logic       timeout;
    logic [0:0] gid;

    up_bus_arbiter_if #(.N(N), .ADDR_WIDTH(AW)) s_if ();
    up_bus_arbiter_if #(.N(1), .ADDR_WIDTH(AW)) m_if ();

    up_bus_arbiter #(
        .NUM_REQ       (N),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_RDATA (DEAD)
    ) dut (
        .up_clk  (clk),
        .up_rstn (rstn),
        .s       (s_if),
        .m       (m_if),
        .busy    (busy),
        .grant_id(gid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Model: one transaction record on a timeline of clock edges.
    // g = grant edge, d = completion edge (-1 while outstanding).
    int          cyc  = 0;
    bit          act  = 0;
    int          g    = 0;
    int          d    = -1;
    int          tid  = 0;
    bit          twr  = 0;
    bit          tto  = 0;
    logic [31:0] trd  = '0;
    int          ptr  = 0;
    int          gidm = 0;
    logic [AW-1:0] lwa = '0;
    logic [31:0]   lwd = '0;
    logic [AW-1:0] lra = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act = 0; d = -1; g = 0; tid = 0; twr = 0; tto = 0;
            trd = '0; ptr = 0; gidm = 0;
            lwa = '0; lwd = '0; lra = '0;
        end else begin
            cyc++;
            if (act) begin
                if (d < 0) begin
                    if (cyc >= g + 2) begin
                        if (twr ? m_if.wack : m_if.rack) begin
                            d = cyc; tto = 0;
                            trd = twr ? 32'h0 : m_if.rdata;
                        end else if (cyc == g + 1 + TO) begin
                            d = cyc; tto = 1;
                            trd = twr ? 32'h0 : DEAD;
                        end
                    end
                end else if (cyc == d + 1) begin
                    act = 0;
                    ptr = (tid + 1) % N;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (ptr + k) % N;
                    if (!act && (s_if.wreq[i] || s_if.rreq[i])) begin
                        act = 1; g = cyc; d = -1; tid = i;
                        twr = s_if.wreq[i]; tto = 0; gidm = i;
                        if (twr) begin
                            lwa = s_if.waddr[i*AW +: AW];
                            lwd = s_if.wdata[i*32 +: 32];
                        end else begin
                            lra = s_if.raddr[i*AW +: AW];
                        end
                    end
                end
            end
        end
    end

    // Bench-side requester and slave state.
    int            ncyc = 0;
    int            lat  = 1;
    bit            stray = 0;
    bit            sl_busy = 0;
    int            sl_cnt = 0;
    bit            sl_wr = 0;
    logic [AW-1:0] sl_addr = '0;
    int            wrep[N];
    int            rrep[N];
    int            wack_n[N];
    int            rack_n[N];
    int            ack_cyc[N];
    logic [31:0]   rd_seen[N];
    int            to_n = 0;
    int            mreq_cyc = 0;
    int            order[$];
    bit            fin;
    int            n0;

    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (timeout) to_n++;
        for (int i = 0; i < N; i++) begin
            if (s_if.wack[i]) begin
                s_if.wreq[i] = 1'b0; wack_n[i]++; ack_cyc[i] = ncyc;
            end else if (!s_if.wreq[i] && wrep[i] > 0) begin
                s_if.wreq[i] = 1'b1; wrep[i]--;
            end
            if (s_if.rack[i]) begin
                s_if.rreq[i] = 1'b0; rack_n[i]++; ack_cyc[i] = ncyc;
                rd_seen[i] = s_if.rdata;
            end else if (!s_if.rreq[i] && rrep[i] > 0) begin
                s_if.rreq[i] = 1'b1; rrep[i]--;
            end
        end
        m_if.wack = 1'b0;
        m_if.rack = 1'b0;
        if (stray) begin
            m_if.rack = 1'b1; m_if.rdata = 32'h0BAD0BAD; stray = 0;
        end
        if (sl_busy) begin
            if (sl_cnt == 0) begin
                if (sl_wr) m_if.wack = 1'b1;
                else begin
                    m_if.rack = 1'b1;
                    m_if.rdata = 32'h100 + 32'(sl_addr);
                end
                sl_busy = 0;
            end else sl_cnt--;
        end
        if (m_if.wreq || m_if.rreq) begin
            mreq_cyc = ncyc;
            order.push_back(int'(gid) * 2 + int'(m_if.wreq));
            if (lat > 0) begin
                sl_busy = 1; sl_cnt = lat - 1;
                sl_wr = m_if.wreq; sl_addr = m_if.raddr;
            end
        end
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            wrep[i] = 0; rrep[i] = 0; wack_n[i] = 0;
            rack_n[i] = 0; ack_cyc[i] = 0; rd_seen[i] = '0;
        end
        order.delete();
        to_n = 0; sl_busy = 0; stray = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        s_if.wreq = '0; s_if.rreq = '0;
        m_if.wack = 1'b0; m_if.rack = 1'b0;
        clr();
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
    endtask

    initial begin
        s_if.wreq = '0; s_if.rreq = '0;
        s_if.waddr = '0; s_if.wdata = '0; s_if.raddr = '0;
        m_if.wack = 1'b0; m_if.rack = 1'b0; m_if.rdata = '0;
        clr();
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gid", gid, 0);
        chk("rst_mwreq", m_if.wreq, 0);
        chk("rst_srack", s_if.rack, 0);
        chk("rst_timeout", timeout, 0);
        #2 rstn = 1'b1;

        fork
            forever begin
                @(negedge clk);
                fin = act && (d == cyc);
                chk("busy", busy, act);
                chk("m_wreq", m_if.wreq, act && twr && cyc == g);
                chk("m_rreq", m_if.rreq, act && !twr && cyc == g);
                chk("m_waddr", m_if.waddr, lwa);
                chk("m_wdata", m_if.wdata, lwd);
                chk("m_raddr", m_if.raddr, lra);
                chk("s_wack", s_if.wack, (fin && twr) ? (1 << tid) : 0);
                chk("s_rack", s_if.rack, (fin && !twr) ? (1 << tid) : 0);
                chk("s_rdata", s_if.rdata, (fin && !twr) ? trd : 0);
                chk("timeout", timeout, fin && tto);
                chk("grant_id", gid, gidm);
            end
        join_none

        // Single write, zero-wait slave.
        lat = 1;
        s_if.waddr[0 +: AW] = 14'h002;
        s_if.wdata[0 +: 32] = 32'h12345678;
        wrep[0] = 1;
        repeat (12) tick();
        chk("wr_ack0", wack_n[0], 1);
        chk("wr_ack1", wack_n[1], 0);
        chk("wr_lat", ack_cyc[0] - mreq_cyc, 2);
        chk("wr_cnt", order.size(), 1);
        chk("wr_addr", m_if.waddr, 14'h002);
        chk("wr_data", m_if.wdata, 32'h12345678);

        // Contention, reads from both requesters.
        do_reset();
        s_if.raddr[0 +: AW] = 14'h000;
        s_if.raddr[AW +: AW] = 14'h001;
        rrep[0] = 2; rrep[1] = 2;
        repeat (30) tick();
        chk("ct_n", order.size(), 4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk("ct_order", order[k], (k % 2) * 2);
        chk("ct_rd0", rd_seen[0], 32'h100);
        chk("ct_rd1", rd_seen[1], 32'h101);
        chk("ct_cnt1", rack_n[1], 2);

        // Mixed: requester 1 asks write and read together.
        do_reset();
        s_if.waddr[AW +: AW] = 14'h003;
        s_if.wdata[32 +: 32] = 32'h0000A5A5;
        s_if.raddr[AW +: AW] = 14'h007;
        rrep[0] = 2; wrep[1] = 1; rrep[1] = 1;
        repeat (30) tick();
        chk("mx_n", order.size(), 4);
        if (order.size() == 4) begin
            chk("mx_o0", order[0], 0);
            chk("mx_o1", order[1], 3);
            chk("mx_o2", order[2], 0);
            chk("mx_o3", order[3], 2);
        end
        chk("mx_rd1", rd_seen[1], 32'h107);

        // Timeout on a silent slave, then a normal write.
        do_reset();
        lat = 0;
        s_if.raddr[0 +: AW] = 14'h005;
        rrep[0] = 1;
        repeat (80) tick();
        chk("to_rack", rack_n[0], 1);
        chk("to_rdata", rd_seen[0], DEAD);
        chk("to_pulse", to_n, 1);
        lat = 1;
        wrep[1] = 1;
        repeat (10) tick();
        chk("to_next", wack_n[1], 1);
        chk("to_pulse2", to_n, 1);

        // Reset in the middle of WAIT.
        do_reset();
        lat = 0;
        s_if.raddr[AW +: AW] = 14'h0AB;
        rrep[1] = 1;
        repeat (6) tick();
        chk("rw_busy", busy, 1);
        chk("rw_gid", gid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rw_busy0", busy, 0);
        chk("rw_gid0", gid, 0);
        chk("rw_rreq0", m_if.rreq, 0);
        chk("rw_rack0", s_if.rack, 0);
        lat = 1;
        n0 = order.size();
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (10) tick();
        chk("rw_again", order.size(), n0 + 1);
        chk("rw_raddr", m_if.raddr, 14'h0AB);
        chk("rw_rack", rack_n[1], 1);
        chk("rw_rd", rd_seen[1], 32'h1AB);

        // Stray read acks while idle and during a write's WAIT.
        do_reset();
        lat = 3;
        repeat (3) tick();
        stray = 1;
        repeat (3) tick();
        chk("st_idle", rack_n[0] + rack_n[1], 0);
        s_if.waddr[0 +: AW] = 14'h010;
        s_if.wdata[0 +: 32] = 32'hCAFEF00D;
        wrep[0] = 1;
        for (int k = 0; k < 10 && order.size() == 0; k++) tick();
        chk("st_grant", order.size(), 1);
        stray = 1;
        repeat (10) tick();
        chk("st_rack", rack_n[0] + rack_n[1], 0);
        chk("st_wack", wack_n[0], 1);
        chk("st_lat", ack_cyc[0] - mreq_cyc, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/up_bus_arbiter.md
Name: up_bus_arbiter

Overview:
- Shares one up_* register-access port (the up_wreq/up_wack/up_rreq/up_rack slave interface that peripheral register banks implement) between NUM_REQ requesters.
- Typical requesters: the up_axi bridge plus local sequencers or DMA-side configurators.
- Serialises transactions one at a time with round-robin fairness and per-transaction ack timeout.
- Returns each ack/rdata only to the requester that issued the transaction.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 14, DWORD address width.
- TIMEOUT_CYCLES, 64, WAIT cycles without downstream ack before forced completion (>=2).
- TIMEOUT_RDATA, 32'hDEADDEAD, rdata returned on read timeout.

Ports:
- up_clk  in  1  clock
- up_rstn  in  1  reset; asynchronous assert, active-low
- s_wreq  in  NUM_REQ  per-requester write request, level, held until s_wack
- s_waddr  in  NUM_REQ*ADDR_WIDTH  write addresses; slice i belongs to requester i
- s_wdata  in  NUM_REQ*32  write data, sliced per requester
- s_wack  out  NUM_REQ  one-cycle write ack
- s_rreq  in  NUM_REQ  read request, level, held until s_rack
- s_raddr  in  NUM_REQ*ADDR_WIDTH  read addresses
- s_rdata  out  32  shared read data, valid only while some s_rack bit is high
- s_rack  out  NUM_REQ  one-cycle read ack
- m_wreq / m_waddr / m_wdata  out  1 / ADDR_WIDTH / 32  downstream write
- m_wack  in  1  downstream write ack
- m_rreq / m_raddr  out  1 / ADDR_WIDTH  downstream read
- m_rdata  in  32  downstream read data
- m_rack  in  1  downstream read ack
- busy  out  1  high in any state other than IDLE
- grant_id  out  clog2(NUM_REQ) (min 1)  index of current or last granted requester
- timeout  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Clock and reset: one clock, up_clk. up_rstn asynchronous, active-low. All outputs and state are registered.
- Reset values: every output 0, state IDLE, round-robin pointer 0, timeout counter 0.
- Requester contract:
  - Assert req with addr/data stable; hold until the matching ack pulse.
  - Deassert req on the edge after ack.
  - A requester may assert wreq and rreq together.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: candidate set = {i : s_wreq[i] | s_rreq[i]}.
  - Winner is the first candidate at or after the pointer, searching upward with wrap.
  - Within the winner, write beats read.
  - On a winner: latch id, type, addr, data; grant_id <= id; go ISSUE.
  - No candidate: stay IDLE.
- ISSUE (exactly 1 cycle):
  - Drive m_wreq or m_rreq high with m_waddr/m_wdata or m_raddr from the latch. Addr/data outputs hold until the next grant.
  - Go WAIT; clear the counter.
- WAIT: m_wreq/m_rreq low.
  - Sample the ack matching the type (m_wack for writes, m_rack for reads). The other ack is ignored.
  - On ack: register m_rdata for reads; go ACK.
  - Otherwise increment the counter. At counter == TIMEOUT_CYCLES-1 with no ack: s_rdata <= TIMEOUT_RDATA (reads only), pulse timeout, go ACK.
- ACK (1 cycle):
  - s_wack[id] or s_rack[id] high; s_rdata valid for reads, 0 otherwise.
  - Pointer <= id+1, wrapping to 0 at NUM_REQ.
  - Go IDLE.
  - Requesters clear req on this edge, so IDLE never sees a stale request.
- Latency (cycle 0 = first edge sampling req in IDLE):
  - m_*req high cycle 0-1.
  - Zero-wait slave (ack registered from req) -> s_*ack high cycle 2-3.
  - Minimum back-to-back throughput: 1 transaction per 4 cycles.
- Ack sampling limits: acks arriving in IDLE, ISSUE or ACK are discarded. A slave ack arriving after a timeout is not protected against; slaves must ack within TIMEOUT_CYCLES.
- Requests arriving while busy wait; none are dropped.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. A pending requester is regranted after reset release if its req is still high.
- NUM_REQ=1: pointer constant 0, grant_id 1 bit = 0.

Test Plan:
- Single write: requester 0 writes addr 0x002, data 0x12345678; slave acks 1 cycle after m_wreq -> m_wreq one cycle with m_waddr=0x002, m_wdata=0x12345678; s_wack[0] pulse 2 edges after m_wreq rise; s_wack[1]=0.
- Contention: both requesters read constantly from 0x000/0x001, slave returns addr+0x100 -> grants alternate 0,1,0,1 starting at 0; each s_rack[i] carries 0x100+i.
- Mixed request: requester 1 asserts wreq and rreq together -> write issued first, read next; with requester 0 active, order is 0,1(w),0,1(r).
- Timeout: read to a slave that never acks, TIMEOUT_CYCLES=64 -> s_rack pulse with s_rdata=0xDEADDEAD; timeout pulse 1 cycle; arbiter returns IDLE and serves the next request normally.
- Reset mid-WAIT: drop up_rstn during WAIT -> busy, m_*req, s_*ack, grant_id go 0 asynchronously; after release, held request is issued again with the same address.
- Stray ack: pulse m_rack while IDLE and during a write's WAIT -> no s_rack generated; write completes only on m_wack.
